// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
//   Y86-64 decode stage. It holds the D pipeline register, the 15-entry
//   architectural register file and the source/destination selection logic.
//   It presents the decoded operands to execute. Pipeline control (stall and
//   bubble) comes from outside the block.
//
//   Optional feature: `define DECODE_FWD_EN turns on operand forwarding from
//   E/M/W. Without it, operands come only from D_valP or the register file,
//   and the forwarding inputs are not used.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   f_stat..f_valP        fetch outputs, captured into the D register
//   D_stall, D_bubble     hold D / load nop into D (stall has priority)
//   e_dstE, e_valE        execute-stage destination and ALU result
//   M_dstE, M_valE        memory-stage destination E and its value
//   M_dstM, m_valM        memory-stage destination M and the read data
//   W_dstE/W_valE,
//   W_dstM/W_valM         writeback; also the two register-file write ports
//   d_stat..d_valC        D register passthrough
//   d_srcA..d_dstM        decoded register indices
//   d_valA, d_valB        operands after valP selection and forwarding
// ----------------------------------------------------------------------------
module decode_stage #(
    parameter logic [3:0] RSP_ID = 4'h4,
    parameter logic [3:0] RNONE  = 4'hF,
    parameter int          NREGS  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  f_stat,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  f_ifun,
    input  logic [3:0]  f_rA,
    input  logic [3:0]  f_rB,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstE,
    input  logic [63:0] M_valE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] m_valM,
    input  logic [3:0]  W_dstE,
    input  logic [63:0] W_valE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valM,
    output logic [3:0]  d_stat,
    output logic [3:0]  d_icode,
    output logic [3:0]  d_ifun,
    output logic [63:0] d_valC,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [3:0]  d_dstE,
    output logic [3:0]  d_dstM,
    output logic [63:0] d_valA,
    output logic [63:0] d_valB
);

    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
    } d_reg_t;

    localparam d_reg_t D_NOP = '{
        stat:  4'b0001,
        icode: 4'h1,
        ifun:  4'h0,
        rA:    RNONE,
        rB:    RNONE,
        valC:  64'h0,
        valP:  64'h0
    };

    d_reg_t      d_r;
    d_reg_t      f_img;
    logic [63:0] regs [NREGS];
    logic [63:0] rf_a, rf_b;

    assign f_img = '{
        stat:  f_stat,
        icode: f_icode,
        ifun:  f_ifun,
        rA:    f_rA,
        rB:    f_rB,
        valC:  f_valC,
        valP:  f_valP
    };

    // D pipeline register: stall holds, and it has priority over bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            d_r <= D_NOP;
        else if (D_stall)
            d_r <= d_r;
        else if (D_bubble)
            d_r <= D_NOP;
        else
            d_r <= f_img;
    end

    // Register file. The M port is written second, so it wins when both
    // ports target the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            if (W_dstE != RNONE)
                regs[W_dstE] <= W_valE;
            if (W_dstM != RNONE)
                regs[W_dstM] <= W_valM;
        end
    end

    assign d_stat  = d_r.stat;
    assign d_icode = d_r.icode;
    assign d_ifun  = d_r.ifun;
    assign d_valC  = d_r.valC;

    // Register selection
    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (d_r.icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = d_r.rA;
            I_RET, I_POPQ:                     d_srcA = RSP_ID;
            default: ;
        endcase
        case (d_r.icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:         d_srcB = d_r.rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:    d_srcB = RSP_ID;
            default: ;
        endcase
        case (d_r.icode)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:         d_dstE = d_r.rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:    d_dstE = RSP_ID;
            default: ;
        endcase
        case (d_r.icode)
            I_MRMOVQ, I_POPQ:                  d_dstM = d_r.rA;
            default: ;
        endcase
    end

    // Combinational read. A same-cycle write is not visible here; the
    // W-stage forwarding entries cover that case.
    always_comb begin
        rf_a = (d_srcA == RNONE) ? 64'h0 : regs[d_srcA];
        rf_b = (d_srcB == RNONE) ? 64'h0 : regs[d_srcB];
    end

`ifdef DECODE_FWD_EN
    // Forwarding. The youngest producer wins. RNONE destinations never match.
    always_comb begin
        d_valA = rf_a;
        if (d_r.icode == I_JXX || d_r.icode == I_CALL)
            d_valA = d_r.valP;
        else if (d_srcA == RNONE)
            d_valA = 64'h0;
        else if (e_dstE != RNONE && e_dstE == d_srcA)
            d_valA = e_valE;
        else if (M_dstM != RNONE && M_dstM == d_srcA)
            d_valA = m_valM;
        else if (M_dstE != RNONE && M_dstE == d_srcA)
            d_valA = M_valE;
        else if (W_dstM != RNONE && W_dstM == d_srcA)
            d_valA = W_valM;
        else if (W_dstE != RNONE && W_dstE == d_srcA)
            d_valA = W_valE;
    end

    always_comb begin
        d_valB = rf_b;
        if (d_srcB == RNONE)
            d_valB = 64'h0;
        else if (e_dstE != RNONE && e_dstE == d_srcB)
            d_valB = e_valE;
        else if (M_dstM != RNONE && M_dstM == d_srcB)
            d_valB = m_valM;
        else if (M_dstE != RNONE && M_dstE == d_srcB)
            d_valB = M_valE;
        else if (W_dstM != RNONE && W_dstM == d_srcB)
            d_valB = W_valM;
        else if (W_dstE != RNONE && W_dstE == d_srcB)
            d_valB = W_valE;
    end
`else
    // No forwarding. Control must stall until writeback has completed.
    // The E/M forwarding inputs are folded into a sink so they stay
    // connected but have no effect.
    logic unused_fwd;
    assign unused_fwd = ^{e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM};

    always_comb begin
        d_valA = rf_a;
        if (d_r.icode == I_JXX || d_r.icode == I_CALL)
            d_valA = d_r.valP;
    end

    assign d_valB = rf_b;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage
//   Stimulus and monitor run as separate processes. Each cycle, the stimulus
//   process predicts the decode outputs from a reference model and queues the
//   prediction. The monitor pops one entry on each falling edge and compares
//   it with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_decode_stage;

    localparam logic [3:0] RN = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  f_stat, f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic        D_stall, D_bubble;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  d_stat, d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM;
    logic [63:0] d_valC, d_valA, d_valB;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
        .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
        .D_stall(D_stall), .D_bubble(D_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_valE(M_valE),
        .M_dstM(M_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM),
        .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_valA(d_valA), .d_valB(d_valB)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  stat, icode, ifun, rA, rB;
        logic [63:0] valC, valP;
    } dmodel_t;

    typedef struct {
        logic [3:0]  stat, icode, ifun, srcA, srcB, dstE, dstM;
        logic [63:0] valC, valA, valB;
    } exp_t;

    dmodel_t     md;
    logic [63:0] mregs [15];
    exp_t        exp_q [$];
    int          errors = 0;
    int          checks = 0;

    function automatic dmodel_t nop_img();
        dmodel_t n;
        n.stat = 4'b0001; n.icode = 4'h1; n.ifun = 4'h0;
        n.rA = RN; n.rB = RN; n.valC = 64'h0; n.valP = 64'h0;
        return n;
    endfunction

    function automatic void model_reset();
        md = nop_img();
        for (int i = 0; i < 15; i++) mregs[i] = 64'h0;
    endfunction

    // Operand value for a source register, following the readout rules:
    // RNONE reads zero, forwarded producers win in age order, else the regfile.
    function automatic logic [63:0] operand(input logic [3:0] src);
        if (src == RN) return 64'h0;
`ifdef DECODE_FWD_EN
        if (e_dstE == src) return e_valE;
        if (M_dstM == src) return m_valM;
        if (M_dstE == src) return M_valE;
        if (W_dstM == src) return W_valM;
        if (W_dstE == src) return W_valE;
`endif
        return mregs[src];
    endfunction

    function automatic exp_t predict();
        exp_t e;
        int   ic;
        ic = int'(md.icode);
        e.stat = md.stat; e.icode = md.icode; e.ifun = md.ifun; e.valC = md.valC;
        e.srcA = (ic inside {2, 4, 6, 10}) ? md.rA : (ic inside {9, 11}) ? 4'h4 : RN;
        e.srcB = (ic inside {4, 5, 6}) ? md.rB : (ic inside {8, 9, 10, 11}) ? 4'h4 : RN;
        e.dstE = (ic inside {2, 3, 6}) ? md.rB : (ic inside {8, 9, 10, 11}) ? 4'h4 : RN;
        e.dstM = (ic inside {5, 11}) ? md.rA : RN;
        e.valA = (ic inside {7, 8}) ? md.valP : operand(e.srcA);
        e.valB = operand(e.srcB);
        return e;
    endfunction

    // Clock-edge effect of the current inputs on the model state.
    function automatic void model_clock();
        if (!D_stall) begin
            if (D_bubble) md = nop_img();
            else begin
                md.stat = f_stat; md.icode = f_icode; md.ifun = f_ifun;
                md.rA = f_rA; md.rB = f_rB; md.valC = f_valC; md.valP = f_valP;
            end
        end
        if (W_dstE != RN) mregs[W_dstE] = W_valE;
        if (W_dstM != RN) mregs[W_dstM] = W_valM;
    endfunction

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("d_stat",  {60'h0, d_stat},  {60'h0, e.stat});
            chk("d_icode", {60'h0, d_icode}, {60'h0, e.icode});
            chk("d_ifun",  {60'h0, d_ifun},  {60'h0, e.ifun});
            chk("d_valC",  d_valC, e.valC);
            chk("d_srcA",  {60'h0, d_srcA},  {60'h0, e.srcA});
            chk("d_srcB",  {60'h0, d_srcB},  {60'h0, e.srcB});
            chk("d_dstE",  {60'h0, d_dstE},  {60'h0, e.dstE});
            chk("d_dstM",  {60'h0, d_dstM},  {60'h0, e.dstM});
            chk("d_valA",  d_valA, e.valA);
            chk("d_valB",  d_valB, e.valB);
        end
    end

    // ---------------- stimulus ----------------
    // Called shortly after a rising edge. The prediction reflects the inputs
    // set now and is checked at the next falling edge.
    task automatic cycle();
        exp_q.push_back(predict());
        @(posedge clk);
        if (rst_n) model_clock();
        #1;
    endtask

    task automatic idle();
        f_stat = 4'b0001; f_icode = 4'h1; f_ifun = 4'h0; f_rA = RN; f_rB = RN;
        f_valC = 64'h0; f_valP = 64'h0;
        D_stall = 1'b0; D_bubble = 1'b0;
        e_dstE = RN; M_dstE = RN; M_dstM = RN; W_dstE = RN; W_dstM = RN;
        e_valE = 64'h0; M_valE = 64'h0; m_valM = 64'h0; W_valE = 64'h0; W_valM = 64'h0;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] vc, input logic [63:0] vp);
        f_stat = 4'b0001; f_icode = ic; f_ifun = 4'h0; f_rA = ra; f_rB = rb;
        f_valC = vc; f_valP = vp;
    endtask

    function automatic logic [3:0] rnd_reg();
        return ($urandom_range(0, 3) == 0) ? RN : 4'($urandom_range(0, 14));
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        cycle();                                 // reset state
        rst_n = 1'b1;
        cycle();

        // regfile write, then read through an OPq
        W_dstE = 4'd3; W_valE = 64'd10;
        cycle();
        idle(); fetch(4'h6, 4'd3, 4'd3, 64'h0, 64'h0);
        cycle();
        idle(); cycle();                         // d_valA=d_valB=10, dstE=3

        // forwarding priority e over M
        fetch(4'h2, 4'd2, 4'd5, 64'h0, 64'h0);
        cycle();
        idle(); D_stall = 1'b1;
        e_dstE = 4'd2; e_valE = 64'd5; M_dstE = 4'd2; M_valE = 64'd9;
        cycle();
        e_dstE = RN;
        cycle();

        // call: valA = valP
        idle(); fetch(4'h8, RN, RN, 64'h100, 64'h2A);
        cycle();
        idle(); cycle();

        // stall / bubble
        fetch(4'h3, RN, 4'd1, 64'h55, 64'h0);
        cycle();
        fetch(4'h5, 4'd2, 4'd3, 64'h0, 64'h0); D_stall = 1'b1;
        cycle(); cycle();
        D_bubble = 1'b1; cycle();
        D_stall = 1'b0; cycle();
        D_bubble = 1'b0; idle(); cycle();

        // same-register dual write: M wins; e_dstE forward only if enabled
        W_dstE = 4'd7; W_dstM = 4'd7; W_valE = 64'd1; W_valM = 64'd2;
        cycle();
        idle(); fetch(4'h2, 4'd7, 4'd1, 64'h0, 64'h0);
        cycle();
        idle(); e_dstE = 4'd7; e_valE = 64'd99; D_stall = 1'b1;
        cycle();
        idle(); cycle();

        // async reset mid-run with an OPq in D
        fetch(4'h6, 4'd1, 4'd2, 64'h0, 64'h0);
        cycle();
        idle(); D_stall = 1'b1; cycle();
        rst_n = 1'b0; model_reset(); cycle();
        rst_n = 1'b1; idle(); cycle();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            f_stat = 4'(1 << $urandom_range(0, 3));
            f_icode = 4'($urandom_range(0, 11)); f_ifun = 4'($urandom_range(0, 6));
            f_rA = rnd_reg(); f_rB = rnd_reg();
            f_valC = rnd64(); f_valP = rnd64();
            D_stall = ($urandom_range(0, 7) == 0);
            D_bubble = ($urandom_range(0, 7) == 0);
            e_dstE = rnd_reg(); M_dstE = rnd_reg(); M_dstM = rnd_reg();
            W_dstE = rnd_reg(); W_dstM = rnd_reg();
            e_valE = rnd64(); M_valE = rnd64(); m_valM = rnd64();
            W_valE = rnd64(); W_valM = rnd64();
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0; model_reset();
                cycle();
                rst_n = 1'b1;
            end else begin
                cycle();
            end
        end

        idle();
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Y86-64 pipeline decode stage, directly downstream of fetch.
- Contains the D pipeline register (captures f_* each cycle), the 15-entry architectural register file, and source/destination register selection.
- Forwards operands from E/M/W and presents decoded operands to execute.
- Pipeline-control stall/bubble requests arrive from outside the block.

Parameters:
RSP_ID, 4'h4, register index of %rsp
RNONE, 4'hF, "no register" index
NREGS, 15, architectural registers (indices 0..14)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
f_stat  in  4  fetch status (bit0 AOK, bit1 INS, bit2 HLT, bit3 ADR)
f_icode  in  4  fetched icode
f_ifun  in  4  fetched ifun
f_rA  in  4  fetched rA
f_rB  in  4  fetched rB
f_valC  in  64  fetched constant
f_valP  in  64  fetched next-PC
D_stall  in  1  hold D register
D_bubble  in  1  load nop into D register
e_dstE  in  4  execute-stage dstE
e_valE  in  64  execute-stage ALU result
M_dstE  in  4  memory-stage dstE
M_valE  in  64  memory-stage valE
M_dstM  in  4  memory-stage dstM
m_valM  in  64  memory read data
W_dstE  in  4  writeback dstE (regfile write port E)
W_valE  in  64  writeback valE
W_dstM  in  4  writeback dstM (regfile write port M)
W_valM  in  64  writeback valM
d_stat  out  4  D_stat passthrough
d_icode  out  4  D_icode
d_ifun  out  4  D_ifun
d_valC  out  64  D_valC
d_srcA  out  4  decoded srcA
d_srcB  out  4  decoded srcB
d_dstE  out  4  decoded dstE
d_dstM  out  4  decoded dstM
d_valA  out  64  operand A after forwarding
d_valB  out  64  operand B after forwarding

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: D register loads the nop image (stat 4'b0001, icode 1, ifun 0, rA=rB=RNONE, valC=valP=0). All 15 registers are cleared to 0. Consequently, during reset, d_srcA/srcB/dstE/dstM=RNONE and d_valA=d_valB=0.
- D register update on rising clk:
  - D_stall=1: hold current contents.
  - else D_bubble=1: load the nop image.
  - else: capture the f_* inputs.
  - D_stall and D_bubble together: stall wins.
- Latency: f_* sampled at edge N appear on d_* after edge N. All d_* outputs are combinational from the D register, the register file and the forwarding inputs.
- srcA: rA for icode 2,4,6,10; RSP_ID for 9,11; else RNONE.
- srcB: rB for 4,5,6; RSP_ID for 8,9,10,11; else RNONE.
- dstE: rB for 2,3,6; RSP_ID for 8,9,10,11; else RNONE.
- dstM: rA for 5,11; else RNONE.
- Register file write, rising clk:
  - Write W_valE to reg[W_dstE] and W_valM to reg[W_dstM].
  - Index RNONE is ignored.
  - W_dstE==W_dstM (not RNONE): the M port wins.
- Register file read: combinational. Index RNONE reads 0. A read of a register written this cycle returns the old value; W-stage forwarding covers the hazard.
- d_valA priority:
  1. D_icode 7 or 8: D_valP.
  2. srcA==RNONE: 0.
  3. First match of srcA among e_dstE→e_valE, M_dstM→m_valM, M_dstE→M_valE, W_dstM→W_valM, W_dstE→W_valE.
  4. Otherwise reg[srcA].
- d_valB: same forwarding chain on srcB, with no valP case.
- Forwarding compares ignore RNONE destinations.
- Load/use hazards are detected outside this block. Decode assumes a stall has already been applied.

Optional Feature:
- Macro DECODE_FWD_EN.
- Defined: forwarding chain as above.
- Undefined: d_valA/d_valB come only from D_valP or the register file. Control must then stall until writeback completes. Forwarding inputs are left unused.

Test Plan:
- Reset asserted mid-run with D holding icode 6 → d_icode=1, d_srcA=d_srcB=4'hF, d_valA=0 immediately, without waiting for a clock edge.
- W_dstE=3, W_valE=10 at edge 1, then fetch 6,rA=3,rB=3 → after edge 2, d_valA=d_valB=10, d_dstE=3.
- D has srcA=2; e_dstE=2 (e_valE=5) and M_dstE=2 (M_valE=9) both present → d_valA=5. Remove e_dstE → 9.
- f_icode 8, f_valP=0x2A, f_valC=0x100 → d_valA=0x2A, d_srcB=4, d_dstE=4, d_valC=0x100.
- D_stall=1 for 2 cycles while f_* changes → d_icode unchanged. D_stall=D_bubble=1 → hold. D_bubble alone → d_icode=1.
- W_dstE=W_dstM=7, W_valE=1, W_valM=2 → reg7=2. Without DECODE_FWD_EN, e_dstE=7 is ignored and d_valA=reg7.
